l2_cacheline_adaptor: RTL and testbench

Burst converter between the L2 cache's physical-memory port and the DRAM model. It accepts one 256-bit line read or write request from L2 and performs it as a four-beat, 64-bit burst. It then returns a single-cycle `resp_o` with the full line. It sits directly downstream of L2 `pmem_read`/`pmem_write`/`pmem_resp` and `pmem_address`.

---
 rtl/l2_cacheline_adaptor_pkg.sv | 26 ++
 rtl/l2_cacheline_adaptor.sv | 125 ++++++++++++
 tb/tb_l2_cacheline_adaptor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cacheline_adaptor_pkg.sv
// Shared cache types: line/burst geometry, request-select enum and line-address helpers.
package l2_cacheline_adaptor_pkg;

  localparam int LINE_BITS   = 256;
  localparam int BURST_BITS  = 64;
  localparam int BEATS       = LINE_BITS / BURST_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE
  } req_e;

  // Writeback wins over fill when L2 raises both in the same cycle.
  function automatic req_e decode_req(input logic rd, input logic wr);
    if (wr) return REQ_WRITE;
    if (rd) return REQ_READ;
    return REQ_NONE;
  endfunction

  function automatic logic [31:0] align_line(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Converts one 256-bit L2 line read/write into a four-beat 64-bit DRAM burst
// and returns a single-cycle completion pulse carrying the full line.
module l2_cacheline_adaptor
  import l2_cacheline_adaptor_pkg::*;
#(
  parameter int LINE_BITS  = l2_cacheline_adaptor_pkg::LINE_BITS,
  parameter int BURST_BITS = l2_cacheline_adaptor_pkg::BURST_BITS,
  parameter int BEATS      = l2_cacheline_adaptor_pkg::BEATS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [31:0]           address_i,
  input  logic [LINE_BITS-1:0]  line_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  resp_o,
  input  logic [BURST_BITS-1:0] burst_i,
  output logic [BURST_BITS-1:0] burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int CNT_BITS = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_e;

  state_e                               state;
  logic   [CNT_BITS-1:0]                cnt;
  logic   [CNT_BITS-1:0]                cnt_next;
  logic                                 last_beat;
  req_e                                 req;
  logic   [BEATS-1:0][BURST_BITS-1:0]   beats_q;
  logic   [BEATS-1:0][BURST_BITS-1:0]   line_next;

  assign req       = decode_req(read_i, write_i);
  assign cnt_next  = cnt + CNT_BITS'(1);
  assign last_beat = (cnt == CNT_BITS'(BEATS - 1));

  // NOTE: every always_comb target gets a full default first so no latch is inferred.
  always_comb begin
    line_next      = beats_q;
    line_next[cnt] = burst_i;
  end

  // NOTE: the beat buffer is pure datapath and deliberately has no reset; every
  // beat is rewritten before it can reach line_o or burst_o.
  always_ff @(posedge clk) begin
    if (state == IDLE && req == REQ_WRITE) begin
      beats_q <= line_i;
    end else if (state == RD_BURST && resp_i) begin
      beats_q[cnt] <= burst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
      line_o    <= '0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          case (req)
            REQ_WRITE: begin
              state     <= WR_BURST;
              write_o   <= 1'b1;
              cnt       <= '0;
              address_o <= align_line(address_i);
              burst_o   <= line_i[BURST_BITS-1:0];
            end
            REQ_READ: begin
              state     <= RD_BURST;
              read_o    <= 1'b1;
              cnt       <= '0;
              address_o <= align_line(address_i);
            end
            default: ;
          endcase
        end
        RD_BURST: begin
          if (resp_i) begin
            cnt <= cnt_next;
            if (last_beat) begin
              state  <= RD_DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              line_o <= line_next;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt_next;
            if (last_beat) begin
              state   <= WR_DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              burst_o <= '0;
            end else begin
              burst_o <= beats_q[cnt_next];
            end
          end
        end
        RD_DONE, WR_DONE: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: read, stalled write, back-to-back,
// simultaneous requests, mid-burst reset and spurious DRAM strobes.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  address_i = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_W = {64'hD3D3_0303_A5A5_0003, 64'hD2D2_0202_5A5A_0002,
                                     64'hD1D1_0101_C3C3_0001, 64'hD0D0_0000_3C3C_0000};
  localparam logic [255:0] LINE_R = {64'hCAFE_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                                     64'hF00D_0000_0000_0002, 64'hFACE_0000_0000_0001};
  localparam logic [255:0] LINE_F = {64'h0F0F_F0F0_1234_5678, 64'h8765_4321_0F0F_F0F0,
                                     64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210};

  l2_cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge and tally completion pulses.
  task automatic tick;
    @(posedge clk);
    #1;
    if (resp_o === 1'b1) pulses++;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [255:0] line, input string tag);
    logic [31:0] exp_addr;
    exp_addr  = {addr[31:5], 5'b0};
    read_i    = 1'b1;
    address_i = addr;
    tick();
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b100) begin
      errors++;
      $display("FAIL %s accept: read/write/resp got %b exp 100", tag, {read_o, write_o, resp_o});
    end
    checks++;
    if (address_o !== exp_addr) begin
      errors++;
      $display("FAIL %s address_o: got %h exp %h", tag, address_o, exp_addr);
    end
    address_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      burst_i = line[64*k +: 64];
      resp_i  = 1'b1;
      tick();
      if (k < 3) begin
        checks++;
        if ({read_o, resp_o} !== 2'b10) begin
          errors++;
          $display("FAIL %s beat%0d: read/resp got %b exp 10", tag, k, {read_o, resp_o});
        end
      end
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    burst_i = '0;
    checks++;
    if ({read_o, resp_o} !== 2'b01) begin
      errors++;
      $display("FAIL %s done: read/resp got %b exp 01", tag, {read_o, resp_o});
    end
    checks++;
    if (line_o !== line) begin
      errors++;
      $display("FAIL %s line_o: got %h exp %h", tag, line_o, line);
    end
    checks++;
    if (address_o !== exp_addr) begin
      errors++;
      $display("FAIL %s address_o held: got %h exp %h", tag, address_o, exp_addr);
    end
  endtask

  // pat bit c is the DRAM strobe in burst cycle c; the bench tracks the expected beat itself.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int n, input logic both,
                           input string tag);
    logic [31:0] exp_addr;
    int          idx;
    exp_addr  = {addr[31:5], 5'b0};
    write_i   = 1'b1;
    read_i    = both;
    line_i    = line;
    address_i = addr;
    tick();
    line_i    = ~line;
    address_i = 32'hFFFF_FFFF;
    idx       = 0;
    for (int c = 0; c < n; c++) begin
      checks++;
      if ({write_o, read_o, resp_o} !== 3'b100) begin
        errors++;
        $display("FAIL %s cyc%0d: write/read/resp got %b exp 100", tag, c,
                 {write_o, read_o, resp_o});
      end
      checks++;
      if (burst_o !== line[64*idx +: 64]) begin
        errors++;
        $display("FAIL %s cyc%0d burst_o: got %h exp %h", tag, c, burst_o, line[64*idx +: 64]);
      end
      resp_i = pat[c];
      if (pat[c]) idx++;
      tick();
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    checks++;
    if ({write_o, resp_o, burst_o} !== {2'b01, 64'h0}) begin
      errors++;
      $display("FAIL %s done: write/resp got %b burst_o %h exp 01 and 0", tag,
               {write_o, resp_o}, burst_o);
    end
    checks++;
    if (address_o !== exp_addr) begin
      errors++;
      $display("FAIL %s address_o: got %h exp %h", tag, address_o, exp_addr);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({resp_o, read_o, write_o, address_o, burst_o, line_o} !== '0) begin
      errors++;
      $display("FAIL %s: resp/read/write %b addr %h burst %h line %h exp all 0", tag,
               {resp_o, read_o, write_o}, address_o, burst_o, line_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_read_no_stall;
    int p0;
    p0 = pulses;
    run_read(32'h0000_1234, LINE_A, "read");
    tick();
    checks++;
    if (resp_o !== 1'b0 || line_o !== LINE_A || pulses !== p0 + 1) begin
      errors++;
      $display("FAIL read after: resp_o %b pulses %0d line %h exp 0, %0d, %h", resp_o,
               pulses - p0, line_o, 1, LINE_A);
    end
  endtask

  task automatic test_write_stalls;
    run_write(32'h8000_00FF, LINE_W, 16'h0033, 6, 1'b0, "write_stall");
    tick();
  endtask

  task automatic test_back_to_back;
    pulses = 0;
    run_write(32'h0000_4000, LINE_W, 16'h000F, 4, 1'b0, "b2b_wr");
    tick();
    checks++;
    if ({resp_o, read_o, write_o} !== 3'b000) begin
      errors++;
      $display("FAIL b2b idle: resp/read/write got %b exp 000", {resp_o, read_o, write_o});
    end
    run_read(32'h0000_5038, LINE_R, "b2b_rd");
    tick();
    tick();
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL b2b pulses: got %0d exp 2", pulses);
    end
  endtask

  task automatic test_simultaneous;
    run_write(32'h1234_5678, LINE_F, 16'h000F, 4, 1'b1, "simul");
    tick();
    checks++;
    if ({read_o, write_o} !== 2'b00) begin
      errors++;
      $display("FAIL simul after: read/write got %b exp 00", {read_o, write_o});
    end
  endtask

  task automatic test_reset_mid_read;
    int p0;
    p0        = pulses;
    read_i    = 1'b1;
    address_i = 32'h0000_0A40;
    tick();
    for (int k = 0; k < 2; k++) begin
      burst_i = LINE_A[64*k +: 64];
      resp_i  = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    checks++;
    if (read_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre: read_o got %b exp 1", read_o);
    end
    rst    = 1'b1;
    read_i = 1'b0;
    tick();
    rst = 1'b0;
    check_all_zero("midrst reset");
    tick();
    check_all_zero("midrst idle");
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL midrst pulses: got %0d exp %0d", pulses - p0, 0);
    end
    run_read(32'h0000_0A40, LINE_F, "midrst_fresh");
    tick();
  endtask

  task automatic test_spurious;
    for (int c = 0; c < 3; c++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom(), $urandom()};
      tick();
      checks++;
      if ({resp_o, read_o, write_o} !== 3'b000 || line_o !== LINE_F || dut.cnt !== 2'd0) begin
        errors++;
        $display("FAIL spurious cyc%0d: resp/read/write %b cnt %0d line %h exp 000, 0, %h", c,
                 {resp_o, read_o, write_o}, dut.cnt, line_o, LINE_F);
      end
    end
    resp_i = 1'b0;
    run_read(32'hFFFF_FFE0, LINE_R, "spurious_rd");
    tick();
  endtask

  initial begin
    test_reset();
    test_read_no_stall();
    test_write_stalls();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_read();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
